// File: rtl/seq_barrel_shifter.sv
// Multi-cycle ARM data-processing barrel shifter: one bit position per SHIFT
// cycle, start/done handshake, full immediate and register shift semantics.
module seq_barrel_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  shift_type,
  input  logic        is_imm,
  input  logic [7:0]  amount,
  input  logic [31:0] operand,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

  state_t      state, state_next;
  op_t         op, op_load;
  logic [5:0]  rem, n_load;
  logic        cin_load;
  logic        accept;
  logic [31:0] step_result;
  logic        step_carry;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Decode the step count, operation and initial carry for a new request.
  always_comb begin
    n_load   = '0;
    cin_load = carry_in;
    unique case (shift_type)
      2'b00:   op_load = OP_LSL;
      2'b01:   op_load = OP_LSR;
      2'b10:   op_load = OP_ASR;
      default: op_load = OP_ROR;
    endcase
    if (is_imm) begin
      if (amount[4:0] == 5'd0) begin
        unique case (shift_type)
          2'b00:        n_load = 6'd0;
          2'b01, 2'b10: n_load = 6'd32;
          default: begin
            n_load  = 6'd1;
            op_load = OP_RRX;
          end
        endcase
      end else begin
        n_load = {1'b0, amount[4:0]};
      end
    end else begin
      unique case (shift_type)
        2'b00, 2'b01: n_load = (amount > 8'd33) ? 6'd33 : amount[5:0];
        2'b10:        n_load = (amount > 8'd32) ? 6'd32 : amount[5:0];
        default: begin
          n_load = {1'b0, amount[4:0]};
          if ((amount != 8'd0) && (amount[4:0] == 5'd0))
            cin_load = operand[31];
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (n_load == 6'd0) ? DONE : SHIFT;
      SHIFT:   if (rem == 6'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RRX always runs exactly one step, so carry_out still holds the latched
  // carry_in when the step shifts it into bit 31.
  always_comb begin
    step_result = result;
    step_carry  = result[0];
    unique case (op)
      OP_LSL: begin
        step_carry  = result[31];
        step_result = {result[30:0], 1'b0};
      end
      OP_LSR:  step_result = {1'b0, result[31:1]};
      OP_ASR:  step_result = {result[31], result[31:1]};
      OP_ROR:  step_result = {result[0], result[31:1]};
      OP_RRX:  step_result = {carry_out, result[31:1]};
      default: step_result = result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The last SHIFT cycle sees rem already at zero and only moves to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry_out <= 1'b0;
      rem       <= '0;
      op        <= OP_LSL;
    end else if (accept) begin
      result    <= operand;
      carry_out <= cin_load;
      op        <= op_load;
      rem       <= n_load;
    end else if ((state == SHIFT) && (rem != 6'd0)) begin
      result    <= step_result;
      carry_out <= step_carry;
      rem       <= rem - 6'd1;
    end
  end

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Self-checking bench for seq_barrel_shifter: directed boundary cases plus
// randomized requests against an arithmetic ARM shifter model.
module tb_seq_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  shift_type;
  logic        is_imm;
  logic [7:0]  amount;
  logic [31:0] operand;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int checks = 0;
  int errors = 0;

  seq_barrel_shifter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shift_type (shift_type),
    .is_imm     (is_imm),
    .amount     (amount),
    .operand    (operand),
    .carry_in   (carry_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // ARM shifter operand semantics; n is the number of single-bit steps.
  task automatic model(input logic [1:0] t, input logic im, input logic [7:0] a,
                       input logic [31:0] op, input logic ci,
                       output logic [31:0] er, output logic ec, output int n);
    int k;
    int r;
    k = im ? int'(a[4:0]) : int'(a);
    if (im && k == 0 && t == 2'b11) begin
      er = {ci, op[31:1]};
      ec = op[0];
      n  = 1;
      return;
    end
    if (im && k == 0 && (t == 2'b01 || t == 2'b10)) k = 32;
    case (t)
      2'b00: begin
        n = (k > 33) ? 33 : k;
        if (k == 0)       begin er = op;      ec = ci;        end
        else if (k < 32)  begin er = op << k; ec = op[32 - k]; end
        else if (k == 32) begin er = '0;      ec = op[0];     end
        else              begin er = '0;      ec = 1'b0;      end
      end
      2'b01: begin
        n = (k > 33) ? 33 : k;
        if (k == 0)       begin er = op;      ec = ci;        end
        else if (k < 32)  begin er = op >> k; ec = op[k - 1]; end
        else if (k == 32) begin er = '0;      ec = op[31];    end
        else              begin er = '0;      ec = 1'b0;      end
      end
      2'b10: begin
        n = (k > 32) ? 32 : k;
        if (k == 0)      begin er = op; ec = ci; end
        else if (k < 32) begin er = $unsigned($signed(op) >>> k); ec = op[k - 1]; end
        else             begin er = {32{op[31]}}; ec = op[31]; end
      end
      default: begin
        r = k % 32;
        n = r;
        if (k == 0)      begin er = op; ec = ci;     end
        else if (r == 0) begin er = op; ec = op[31]; end
        else begin
          er = (op >> r) | (op << (32 - r));
          ec = op[r - 1];
        end
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] t, input logic im,
                        input logic [7:0] a, input logic [31:0] op, input logic ci);
    logic [31:0] er;
    logic        ec;
    int          n;
    int          edges;
    model(t, im, a, op, ci, er, ec, n);
    @(negedge clk);
    shift_type = t; is_imm = im; amount = a; operand = op; carry_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    shift_type = 2'($urandom); is_imm = 1'($urandom); amount = 8'($urandom);
    operand = $urandom; carry_in = 1'($urandom);
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    edges = 0;
    while (!done && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), (n == 0) ? 32'd0 : 32'(n + 1));
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, 32'(carry_out), 32'(ec));
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ra;
    logic [31:0] saved;
    int          dones;
    rst_n = 1'b0; start = 1'b0; shift_type = '0; is_imm = 1'b0;
    amount = '0; operand = '0; carry_in = 1'b0;
    #12;
    check("reset_outs", {busy, done, carry_out}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("lsl_reg4",  2'b00, 1'b0, 8'd4,  32'h0000000F, 1'b0);
    run_op("lsr_imm0",  2'b01, 1'b1, 8'd0,  32'h80000000, 1'b0);
    run_op("asr_reg40", 2'b10, 1'b0, 8'd40, 32'h80000000, 1'b0);
    run_op("rrx",       2'b11, 1'b1, 8'd0,  32'h00000003, 1'b1);
    run_op("lsl_reg33", 2'b00, 1'b0, 8'd33, 32'hFFFFFFFF, 1'b0);
    run_op("lsl_reg32", 2'b00, 1'b0, 8'd32, 32'hFFFFFFFF, 1'b0);
    run_op("ror_reg32", 2'b11, 1'b0, 8'd32, 32'h80000000, 1'b0);
    run_op("lsl_reg0",  2'b00, 1'b0, 8'd0,  32'h12345678, 1'b1);
    run_op("lsl_imm0",  2'b00, 1'b1, 8'hE0, 32'hCAFEF00D, 1'b1);
    run_op("lsr_reg200",2'b01, 1'b0, 8'd200,32'hFFFFFFFF, 1'b1);

    // start held high through a 10-step ROR: one done, then re-accepted.
    @(negedge clk);
    shift_type = 2'b11; is_imm = 1'b0; amount = 8'd10; operand = 32'h0000000F;
    carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (i == 11) begin
        check("ror10_result", result, 32'h03C00000);
        check("ror10_carry", 32'(carry_out), 32'd0);
      end
    end
    check("ror10_dones", 32'(dones), 32'd1);
    check("ror10_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("ror10_reaccept", 32'(busy), 32'd1);
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
    end
    check("ror10_second", result, 32'h03C00000);
    @(posedge clk); #1;

    // Reset at step 5 of a 20-step LSR aborts without a done pulse.
    @(negedge clk);
    shift_type = 2'b01; is_imm = 1'b0; amount = 8'd20; operand = 32'hDEADBEEF;
    carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    saved = result;
    check("pre_reset_step5", saved, 32'hDEADBEEF >> 5);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_flags", {busy, done, carry_out}, 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 2'b01, 1'b0, 8'd20, 32'hDEADBEEF, 1'b1);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 8'($urandom_range(0, 40));
        1:       ra = {3'($urandom), 5'd0};
        2:       ra = 8'($urandom);
        default: ra = 8'($urandom_range(30, 34));
      endcase
      run_op("rand", 2'($urandom), 1'($urandom), ra, $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
